shifter_arbiter: RTL
====================

# shifter_arbiter

Sequential front-end for the shared 8-bit barrel shifter. It arbitrates between two requesters (ALU-side shift path and an auxiliary/immediate path) with round-robin fairness. It latches the granted operands, normalises the shift amount, and holds the shifter inputs stable for a programmable settle window. It then captures the shifter output and returns it with a one-cycle acknowledge to the granted requester.

## Interface
- SETTLE_CYCLES, default 1: cycles the shifter inputs are held before the result is sampled; legal range 1..15.
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ0 / REQ1  input  1  shift request from requester 0 / 1; level, held until ACK.
- OP0 / OP1  input  2  shift op: 00 srl, 01 sra, 10 ror, 11 sll.
- DATA0 / DATA1  input  8  operand to shift.
- AMNT0 / AMNT1  input  8  unsigned shift amount.
- ACK0 / ACK1  output  1  one-cycle pulse; RESULT is valid for that requester in the same cycle.
- RESULT  output  8  registered shift result; holds last value between acks.
- BUSY  output  1  high in every non-IDLE state.
- SH_INPUT  output  8  operand to barrel shifter.
- SH_AMNT  output  8  normalised amount to barrel shifter; bits 7:4 always 0.
- SH_OP  output  2  op to barrel shifter, same encoding as OPx.
- SH_RESULT  input  8  barrel shifter output.

## Operation
- FSM states are IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE with no REQ: all outputs hold; ACKx=0.
- IDLE with any REQ: grant, latch DATA/OP/normalised AMNT of the winner into SH_* registers, load the settle counter with SETTLE_CYCLES-1, and go to BUSY.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high: the requester not granted last wins.
  - LAST_GNT resets to 1, so requester 0 wins the first tie.
- BUSY: decrement the counter each cycle. When the counter reaches 0, register SH_RESULT into RESULT and go to DONE.
- DONE: pulse ACKx of the granted requester for exactly one cycle, update LAST_GNT, then go to IDLE. No arbitration happens in DONE.
- A REQ still high in IDLE after its ACK is treated as a new transaction.
- A REQ that drops during BUSY is ignored: the transaction completes and ACK is still issued.
- SH_INPUT, SH_AMNT and SH_OP change only on the IDLE→BUSY edge. They are stable throughout BUSY and DONE.
- Amount normalisation, where A = AMNTx:
  - ror: SH_AMNT = {5'b0, A[2:0]} (mod 8).
  - srl, sra, sll: SH_AMNT = (A ≥ 8) ? 8 : A.
  - Effect on the shifter: amounts ≥ 8 give 0x00 for srl/sll and sign-fill for sra.
- Reset mid-operation: the next state is IDLE and every output returns to its reset value. The in-flight transaction is dropped with no ACK.
- Reset values: ACK0=ACK1=0, BUSY=0, RESULT=0, SH_INPUT=0, SH_AMNT=0, SH_OP=00, LAST_GNT=1, counter=0.

## Timing
- REQ is sampled high in IDLE in cycle 0.
- BUSY runs in cycles 1..SETTLE_CYCLES.
- RESULT is captured at the end of cycle SETTLE_CYCLES.
- ACK and valid RESULT appear in cycle SETTLE_CYCLES+1.
- IDLE is reached in cycle SETTLE_CYCLES+2.
- Turnaround is SETTLE_CYCLES+2 cycles per transaction. With SETTLE_CYCLES=1, ACK comes 2 cycles after REQ is sampled and a new grant is possible every 3 cycles.
- All outputs are registered; there is no combinational path from REQ/DATA to any output.

## Structure
- Shared package shift_pkg holds:
  - the SHIFTOP encodings (SHIFT_SRL=2'b00, SHIFT_SRA=2'b01, SHIFT_ROR=2'b10, SHIFT_SLL=2'b11);
  - the FSM state encoding (IDLE, BUSY, DONE);
  - the MAX_LOGICAL_AMNT=8 constant.
- Sub-module rr_arbiter2 contains the 2-way round-robin arbiter with the LAST_GNT register and an update strobe driven in DONE.
- Top level holds the FSM, settle counter, operand/amount registers and result register. The barrel shifter is instantiated outside and connected via the SH_* ports.

## Test plan
- Single request: REQ0, OP 00, DATA 8'hB4, AMNT 2, SETTLE_CYCLES=1 → ACK0 two cycles after sampling, RESULT 8'h2D, ACK1 never high.
- Tie after reset: REQ0 sll 8'h81 amnt 1 and REQ1 sra 8'h80 amnt 3 raised together → ACK0 first with 8'h02, then ACK1 three cycles later with 8'hF0.
- Rotate normalisation: REQ1 ror 8'h01 amnt 10 → SH_AMNT 2 during BUSY, RESULT 8'h40.
- Clamp: srl 8'hFF amnt 200 → SH_AMNT 8, RESULT 8'h00. sra 8'h80 amnt 9 → SH_AMNT 8, RESULT 8'hFF.
- Reset mid-BUSY (SETTLE_CYCLES=4, RESET in the 2nd BUSY cycle) → next cycle BUSY=0, all SH_* and RESULT 0, no ACK. A following REQ0 completes normally.
- Fairness: REQ0 and REQ1 held continuously for 4 transactions → ACK order 0,1,0,1, with each SH_INPUT matching the granted DATAx.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the barrel-shifter front-end: op encodings, FSM states and
// the amount normalisation used on the shifter inputs.
package shift_pkg;

    typedef logic [1:0] shift_op_t;
    typedef logic [1:0] state_t;

    localparam shift_op_t SHIFT_SRL = 2'b00;
    localparam shift_op_t SHIFT_SRA = 2'b01;
    localparam shift_op_t SHIFT_ROR = 2'b10;
    localparam shift_op_t SHIFT_SLL = 2'b11;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_BUSY = 2'b01;
    localparam state_t ST_DONE = 2'b10;

    localparam logic [7:0] MAX_LOGICAL_AMNT = 8'd8;
    localparam int unsigned CNT_W = 4;

    // Rotates wrap modulo 8; logical/arithmetic shifts saturate at 8 so the shifter
    // never sees more than a full-width shift.
    function automatic logic [7:0] norm_amnt(input shift_op_t op, input logic [7:0] amnt);
        logic [7:0] res;
        if (op == SHIFT_ROR) begin
            res = {5'b0, amnt[2:0]};
        end else if (amnt >= MAX_LOGICAL_AMNT) begin
            res = MAX_LOGICAL_AMNT;
        end else begin
            res = amnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer advances only when the owner
// of a completed transaction is reported through the update strobe.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic update_id,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_gnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else if (update) begin
            last_gnt_q <= update_id;
        end
    end

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_gnt_q;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Arbitrating front-end for the shared barrel shifter: latches the winner's operands,
// holds them for the settle window, then returns the captured result with an ack pulse.
module shifter_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      req0,
    input  logic      req1,
    input  shift_op_t op0,
    input  shift_op_t op1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] amnt0,
    input  logic [7:0] amnt1,
    output logic      ack0,
    output logic      ack1,
    output logic [7:0] result,
    output logic      busy,
    output logic [7:0] sh_input,
    output logic [7:0] sh_amnt,
    output shift_op_t sh_op,
    input  logic [7:0] sh_result
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic [7:0]       sh_input_q, sh_input_d;
    logic [7:0]       sh_amnt_q, sh_amnt_d;
    shift_op_t        sh_op_q, sh_op_d;
    logic [7:0]       result_q, result_d;
    logic             busy_q, busy_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic gnt_valid;
    logic gnt_id;
    logic arb_update;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .update    (arb_update),
        .update_id (owner_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        sh_input_d = sh_input_q;
        sh_amnt_d  = sh_amnt_q;
        sh_op_d    = sh_op_q;
        result_d   = result_q;
        busy_d     = busy_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        arb_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d    = ST_BUSY;
                    busy_d     = 1'b1;
                    owner_d    = gnt_id;
                    cnt_d      = SETTLE_LOAD;
                    sh_input_d = gnt_id ? data1 : data0;
                    sh_op_d    = gnt_id ? op1 : op0;
                    sh_amnt_d  = gnt_id ? norm_amnt(op1, amnt1) : norm_amnt(op0, amnt0);
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    result_d = sh_result;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                arb_update = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            sh_input_q <= '0;
            sh_amnt_q  <= '0;
            sh_op_q    <= SHIFT_SRL;
            result_q   <= '0;
            busy_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            sh_input_q <= sh_input_d;
            sh_amnt_q  <= sh_amnt_d;
            sh_op_q    <= sh_op_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign sh_input = sh_input_q;
    assign sh_amnt  = sh_amnt_q;
    assign sh_op    = sh_op_q;

endmodule
